// File: rtl/v6502_pkg.sv
// Shared types and defaults for the v6502 instruction front end.
package v6502_pkg;

    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        STREAM = 2'd2
    } prefetch_state_t;

    localparam logic [15:0] RST_VEC_DEF    = 16'hFFFC;
    localparam int          PREFETCH_DEPTH = 16;

endpackage

// File: rtl/prefetch_fifo.sv
// Byte queue for the instruction prefetcher: 1-byte push, 1..3-byte pop,
// flush, and the three head bytes presented combinationally.
module prefetch_fifo #(
    parameter  int DEPTH = 16,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    input  logic [1:0]    pop_len,
    output logic [CW-1:0] count,
    output logic [7:0]    head0,
    output logic [7:0]    head1,
    output logic [7:0]    head2
);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(pop_len);
            count <= count + CW'(push) - (pop ? CW'(pop_len) : CW'(0));
        end
    end

    // Storage carries no reset; occupancy gating below hides stale entries.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head0 = (count > CW'(0)) ? mem[rd_ptr]          : 8'h00;
    assign head1 = (count > CW'(1)) ? mem[rd_ptr + PW'(1)] : 8'h00;
    assign head2 = (count > CW'(2)) ? mem[rd_ptr + PW'(2)] : 8'h00;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: fetches the reset vector, then streams bytes from
// fetch_pc into a byte queue consumed 1..3 bytes at a time.
module inst_prefetch
    import v6502_pkg::*;
#(
    parameter int          DEPTH   = PREFETCH_DEPTH,
    parameter logic [15:0] RST_VEC = RST_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        pull,
    input  logic [1:0]  pull_len,
    output logic [4:0]  q_len,
    output logic [7:0]  q_byte0,
    output logic [7:0]  q_byte1,
    output logic [7:0]  q_byte2,
    output logic [15:0] q_pc,
    output logic        pull_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    prefetch_state_t state, state_nxt;
    logic [15:0]     fetch_pc, fetch_pc_nxt, q_pc_nxt;
    logic [7:0]      vec_lo, vec_lo_nxt;
    logic            pull_err_nxt;
    logic            push, pop, room, pull_ok;
    logic [CW-1:0]   count;

    assign room    = (count < CW'(DEPTH));
    assign pull_ok = pull && (pull_len != 2'd0) && (CW'(pull_len) <= count);
    assign q_len   = 5'(count);

    always_comb begin
        unique case (state)
            VEC_LO:  mem_addr = RST_VEC;
            VEC_HI:  mem_addr = RST_VEC + 16'd1;
            default: mem_addr = fetch_pc;
        endcase
    end

    // The request is dropped in the redirect cycle so nothing from the old
    // stream can be accepted once the flush is under way.
    assign mem_rd = rst_n && !redirect && ((state != STREAM) || room);

    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        q_pc_nxt     = q_pc;
        vec_lo_nxt   = vec_lo;
        push         = 1'b0;
        pop          = 1'b0;
        pull_err_nxt = 1'b0;
        if (redirect) begin
            state_nxt    = STREAM;
            fetch_pc_nxt = redirect_pc;
            q_pc_nxt     = redirect_pc;
        end else begin
            pop          = pull_ok;
            pull_err_nxt = pull && !pull_ok;
            if (pull_ok)
                q_pc_nxt = q_pc + 16'(pull_len);
            unique case (state)
                VEC_LO: begin
                    if (mem_ready) begin
                        vec_lo_nxt = mem_rdata;
                        state_nxt  = VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (mem_ready) begin
                        fetch_pc_nxt = {mem_rdata, vec_lo};
                        q_pc_nxt     = {mem_rdata, vec_lo};
                        state_nxt    = STREAM;
                    end
                end
                STREAM: begin
                    if (room && mem_ready) begin
                        push         = 1'b1;
                        fetch_pc_nxt = fetch_pc + 16'd1;
                    end
                end
                default: state_nxt = VEC_LO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= VEC_LO;
            fetch_pc <= '0;
            q_pc     <= '0;
            pull_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            q_pc     <= q_pc_nxt;
            pull_err <= pull_err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        vec_lo <= vec_lo_nxt;
    end

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pop),
        .pop_len   (pull_len),
        .count     (count),
        .head0     (q_byte0),
        .head1     (q_byte1),
        .head2     (q_byte2)
    );

endmodule
